bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, sets the address width of both ports and of the bus controller address.
REQ-002 Parameter DATA_W, default 8, sets the data width of both ports and of the bus controller data.
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 p0_req, p0_type, p0_addr, p0_wdata  input  1/2/ADDR_W/DATA_W  port 0 (instruction fetch) request, access type, address, write data.
REQ-006 p1_req, p1_type, p1_addr, p1_wdata  input  1/2/ADDR_W/DATA_W  port 1 (data/char access), same meaning as port 0.
REQ-007 p0_done, p1_done  output  1 each  one-cycle completion pulse for the owning port.
REQ-008 rdata  output  DATA_W  read data of the last completed transaction, shared by both ports.
REQ-009 mreq, mtype, maddr, mwdata  output  1/2/ADDR_W/DATA_W  request, type, address and write data driven to bus_controller.
REQ-010 mdone, mrdata  input  1/DATA_W  completion flag and read data from bus_controller.
REQ-011 busy, owner  output  1/1  busy = a transaction is in flight; owner = granted port (0 or 1).

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ISSUE, BUSY and RELEASE.
REQ-013 IDLE -> ISSUE SHALL occur on a clock where at least one req is high and mdone is 0; with mdone high, the FSM SHALL remain in IDLE.
REQ-014 Arbitration SHALL be round-robin: when both req are high, the port not granted last SHALL win.
REQ-015 A single requester SHALL win regardless of history.
REQ-016 On grant, the arbiter SHALL latch the winner's type, addr and wdata into mtype, maddr and mwdata, latch the winner into owner, and update last_grant.
REQ-017 mtype, maddr and mwdata SHALL stay stable until the next grant.
REQ-018 ISSUE SHALL assert mreq on the next cycle; mreq SHALL rise exactly 2 clocks after req is first sampled high in IDLE, and the FSM SHALL go to BUSY.
REQ-019 BUSY SHALL hold mreq high until mdone = 1.
REQ-020 On that clock the arbiter SHALL register mrdata into rdata, pulse the owner's done for exactly one cycle, drop mreq, and go to RELEASE.
REQ-021 RELEASE SHALL keep mreq low and go to IDLE on the first clock with mdone = 0.
REQ-022 req SHALL be ignored in ISSUE, BUSY and RELEASE.
REQ-023 Consecutive transactions SHALL be separated by at least one IDLE cycle.
REQ-024 A requester SHALL hold req, type, addr and wdata until its done pulse and SHALL drop req the cycle after done.
REQ-025 A req deasserted mid-transaction SHALL NOT abort the transaction; done SHALL still pulse.
REQ-026 The non-owner's done SHALL stay 0 throughout.
REQ-027 rdata SHALL update only on a completion clock, for write types as well.
REQ-028 busy SHALL be 1 exactly in the ISSUE, BUSY and RELEASE states.
REQ-029 No combinational path SHALL exist from any input to any output.

Reset
REQ-030 While rst_n = 0 at a clock edge: state = IDLE, mreq = 0, p0_done = p1_done = 0, busy = 0, owner = 0, mtype = 0, maddr = 0, mwdata = 0, rdata = 0, last_grant = 1 (port 0 wins the first contention).
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse.
REQ-032 After reset release, the first grant SHALL wait for mdone = 0 (per REQ-013).

Structure
REQ-033 The mtype encodings (RDATA = 0, WDATA = 1, RCHAR = 2, WCHAR = 3) SHALL be defined in the shared params.vh, used by bus_arbiter and bus_controller; the FSM state encodings SHALL stay local to bus_arbiter.
REQ-034 The round-robin winner selection MAY be a sub-module rr_pick2 (inputs req0, req1, last; outputs gnt_valid, gnt_id); no other sub-modules.

Verification
REQ-035 Single read: p0 RDATA to addr 0x000123, mdone high 3 clocks after mreq with mrdata 0x5A -> mreq 2 clocks after req, maddr 0x000123, p0_done 1 cycle, rdata 0x5A, p1_done 0.
REQ-036 Contention: p0 and p1 requesting continuously from reset -> grant order p0, p1, p0, p1; an IDLE cycle between each pair; no overlapping mreq.
REQ-037 Write: p1 WCHAR with wdata 0x41 -> mtype 3, mwdata 0x41 held stable while mreq is high; p1_done 1 cycle; rdata updates to mrdata.
REQ-038 Stale mdone: mdone held high with p0 requesting for 4 clocks -> mreq stays 0; grant follows the first clock with mdone = 0.
REQ-039 Reset mid-BUSY: rst_n low for 1 clock while mreq high -> next cycle mreq 0, busy 0, no done pulse, owner 0; a fresh p1 request then completes normally.
REQ-040 Early drop: p0 drops req during BUSY -> the transaction completes and p0_done still pulses once.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter and its bus controller.
package bus_arbiter_pkg;

  // Access type presented on mtype; bus_controller decodes the same values.
  typedef enum logic [1:0] {
    RDATA = 2'd0,
    WDATA = 2'd1,
    RCHAR = 2'd2,
    WCHAR = 2'd3
  } mtype_e;

  localparam int unsigned ADDR_W_DEFAULT = 24;
  localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter <-> bus_controller handshake: one request in flight, completion on mdone.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);
  logic              mreq;
  mtype_e            mtype;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic              mdone;
  logic [DATA_W-1:0] mrdata;

  modport master (output mreq, mtype, maddr, mwdata, input mdone, mrdata);
  modport slave  (input mreq, mtype, maddr, mwdata, output mdone, mrdata);
endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin winner selection.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // Port 1 wins when alone, or when both ask and port 0 was served last.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates instruction-fetch (port 0) and data (port 1) requests onto a
// single bus_controller, one transaction at a time.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [1:0]        p0_type,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic [1:0]        p1_type,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_done,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  bus_arbiter_if.master     mbus,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RELEASE
  } state_e;

  state_e state_q, state_d;
  logic   last_q;
  logic   gnt_valid, gnt_id;
  logic   grant, complete;

  rr_pick2 u_pick (
    .req0      (p0_req),
    .req1      (p1_req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // mreq and busy decode from the state register only, so no input reaches an output.
  assign mbus.mreq = (state_q == S_BUSY);
  assign busy      = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus the grant/complete strobes for the datapath.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A stale mdone from the previous transaction blocks the next grant.
        if (gnt_valid && !mbus.mdone) begin
          state_d = S_ISSUE;
          grant   = 1'b1;
        end
      end
      S_ISSUE: state_d = S_BUSY;
      S_BUSY: begin
        if (mbus.mdone) begin
          state_d  = S_RELEASE;
          complete = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!mbus.mdone) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant capture, completion pulse and read-data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      last_q      <= 1'b1;
      mbus.mtype  <= RDATA;
      mbus.maddr  <= '0;
      mbus.mwdata <= '0;
      rdata       <= '0;
      p0_done     <= 1'b0;
      p1_done     <= 1'b0;
    end else begin
      p0_done <= complete & ~owner;
      p1_done <= complete &  owner;
      if (complete) rdata <= mbus.mrdata;
      if (grant) begin
        owner       <= gnt_id;
        last_q      <= gnt_id;
        mbus.mtype  <= mtype_e'(gnt_id ? p1_type : p0_type);
        mbus.maddr  <= gnt_id ? p1_addr  : p0_addr;
        mbus.mwdata <= gnt_id ? p1_wdata : p0_wdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p1_req;
  logic [1:0]    p0_type, p1_type;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_done, p1_done, busy, owner;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_type(p0_type), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_type(p1_type), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_done(p0_done), .p1_done(p1_done), .rdata(rdata),
    .mbus(mbus), .busy(busy), .owner(owner)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus controller stand-in: mdone for one cycle lat clocks after mreq rises.
  bit            stale = 1'b0;
  int unsigned   lat = 3;
  logic [DW-1:0] rd_val = '0;
  int unsigned   ccnt = 0;
  always @(posedge clk) begin
    #1;
    if (mbus.mreq) ccnt = ccnt + 1;
    else           ccnt = 0;
    if (stale) begin
      mbus.mdone  = 1'b1;
      mbus.mrdata = DW'($urandom);
    end else if (mbus.mreq && ccnt == lat) begin
      mbus.mdone  = 1'b1;
      mbus.mrdata = rd_val;
    end else begin
      mbus.mdone  = 1'b0;
      mbus.mrdata = DW'($urandom);
    end
  end

  // Reference model: a transaction is granted, issued one cycle later, finishes
  // on the first mdone seen while issued, then lingers until mdone falls.
  bit            m_valid = 1'b0;
  bit            m_active, m_complete, m_owner, m_last, m_done0, m_done1;
  int unsigned   m_age;
  logic [1:0]    m_mtype;
  logic [AW-1:0] m_maddr;
  logic [DW-1:0] m_mwdata, m_rdata;
  always @(posedge clk) begin : model
    bit w;
    if (!rst_n) begin
      m_valid = 1'b1; m_active = 1'b0; m_complete = 1'b0; m_age = 0;
      m_owner = 1'b0; m_last = 1'b1; m_done0 = 1'b0; m_done1 = 1'b0;
      m_mtype = 2'd0; m_maddr = '0; m_mwdata = '0; m_rdata = '0;
    end else begin
      m_done0 = 1'b0;
      m_done1 = 1'b0;
      if (!m_active) begin
        if ((p0_req || p1_req) && !mbus.mdone) begin
          if (p0_req && p1_req) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
          else                  w = p1_req;
          m_active = 1'b1; m_complete = 1'b0; m_age = 0;
          m_owner = w; m_last = w;
          m_mtype  = w ? p1_type  : p0_type;
          m_maddr  = w ? p1_addr  : p0_addr;
          m_mwdata = w ? p1_wdata : p0_wdata;
        end
      end else if (!m_complete) begin
        if (m_age >= 1 && mbus.mdone) begin
          m_complete = 1'b1;
          m_rdata = mbus.mrdata;
          if (m_owner) m_done1 = 1'b1;
          else         m_done0 = 1'b1;
        end
        m_age++;
      end else if (!mbus.mdone) begin
        m_active = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",    32'(busy),        32'(m_active));
      chk("mreq",    32'(mbus.mreq),   32'(m_active && m_age >= 1 && !m_complete));
      chk("owner",   32'(owner),       32'(m_owner));
      chk("p0_done", 32'(p0_done),     32'(m_done0));
      chk("p1_done", 32'(p1_done),     32'(m_done1));
      chk("rdata",   32'(rdata),       32'(m_rdata));
      chk("mtype",   32'(mbus.mtype),  32'(m_mtype));
      chk("maddr",   32'(mbus.maddr),  32'(m_maddr));
      chk("mwdata",  32'(mbus.mwdata), 32'(m_mwdata));
    end
  end

  // Event monitor feeding the hand-computed checks.
  int unsigned   d0_cnt = 0, d1_cnt = 0, rise_cnt = 0, last_rise_cyc = 0, gap_bad = 0;
  bit            prev_mreq = 1'b0, idle_seen = 1'b1;
  int            gnt_q[$];
  logic [1:0]    rise_mtype;
  logic [AW-1:0] rise_maddr;
  logic [DW-1:0] rise_mwdata;
  always @(negedge clk) begin
    if (p0_done) d0_cnt++;
    if (p1_done) d1_cnt++;
    if (!busy) idle_seen = 1'b1;
    if (mbus.mreq && !prev_mreq) begin
      rise_cnt++;
      last_rise_cyc = cyc;
      gnt_q.push_back(int'(owner));
      rise_mtype  = mbus.mtype;
      rise_maddr  = mbus.maddr;
      rise_mwdata = mbus.mwdata;
      if (!idle_seen) gap_bad++;
      idle_seen = 1'b0;
    end
    prev_mreq = mbus.mreq;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting, got none expected event", name);
  endtask

  task automatic wait_rise(input int unsigned target, input int unsigned maxc, input string name);
    int unsigned n = 0;
    while (rise_cnt < target && n < maxc) begin step(); n++; end
    if (rise_cnt < target) timeout(name);
  endtask

  task automatic wait_done(input bit port, input int unsigned prev, input int unsigned maxc,
                           input string name);
    int unsigned n = 0;
    while (((port ? d1_cnt : d0_cnt) == prev) && n < maxc) begin step(); n++; end
    if ((port ? d1_cnt : d0_cnt) == prev) timeout(name);
  endtask

  task automatic wait_idle(input int unsigned maxc, input string name);
    int unsigned n = 0;
    while (busy && n < maxc) begin step(); n++; end
    if (busy) timeout(name);
  endtask

  initial begin : stim
    int unsigned t0, r0, c0, c1, g0;
    int          exp_g[4];
    exp_g = '{0, 1, 0, 1};

    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    p0_type = 2'd0; p1_type = 2'd0; p0_addr = '0; p1_addr = '0;
    p0_wdata = '0; p1_wdata = '0;
    repeat (3) step();
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_mreq",  32'(mbus.mreq), 32'd0);
    chk("rst_owner", 32'(owner),     32'd0);
    chk("rst_rdata", 32'(rdata),     32'd0);
    rst_n = 1'b1;
    step();

    // Single read from port 0.
    lat = 3; rd_val = 8'h5A;
    p0_type = 2'd0; p0_addr = 24'h000123; p0_req = 1'b1;
    t0 = cyc; r0 = rise_cnt; c0 = d0_cnt; c1 = d1_cnt;
    wait_rise(r0 + 1, 10, "t1_rise");
    chk("t1_mreq_latency", last_rise_cyc - t0, 32'd2);
    chk("t1_maddr", 32'(rise_maddr), 32'h000123);
    wait_done(1'b0, c0, 20, "t1_done");
    p0_req = 1'b0;
    step(); step();
    chk("t1_done_once", d0_cnt - c0, 32'd1);
    chk("t1_rdata", 32'(rdata), 32'h5A);
    chk("t1_p1_quiet", d1_cnt - c1, 32'd0);

    // Contention from reset: grants alternate starting with port 0.
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    gnt_q.delete(); g0 = gap_bad; r0 = rise_cnt; c0 = d0_cnt; c1 = d1_cnt;
    lat = 2; rd_val = 8'hC3;
    p0_type = 2'd0; p0_addr = 24'h000100;
    p1_type = 2'd2; p1_addr = 24'h000200;
    p0_req = 1'b1; p1_req = 1'b1;
    wait_rise(r0 + 4, 80, "t2_rises");
    p0_req = 1'b0; p1_req = 1'b0;
    wait_idle(20, "t2_idle");
    chk("t2_ngrant", gnt_q.size(), 32'd4);
    if (gnt_q.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), gnt_q[i], exp_g[i]);
    chk("t2_gaps", gap_bad - g0, 32'd0);
    chk("t2_p0_dones", d0_cnt - c0, 32'd2);
    chk("t2_p1_dones", d1_cnt - c1, 32'd2);
    step();

    // Port 1 character write.
    lat = 3; rd_val = 8'h77;
    p1_type = 2'd3; p1_addr = 24'h00ABCD; p1_wdata = 8'h41; p1_req = 1'b1;
    r0 = rise_cnt; c0 = d0_cnt; c1 = d1_cnt;
    wait_rise(r0 + 1, 10, "t3_rise");
    chk("t3_mtype", 32'(rise_mtype), 32'd3);
    chk("t3_mwdata", 32'(rise_mwdata), 32'h41);
    wait_done(1'b1, c1, 20, "t3_done");
    p1_req = 1'b0;
    step(); step();
    chk("t3_rdata", 32'(rdata), 32'h77);
    chk("t3_done_once", d1_cnt - c1, 32'd1);
    chk("t3_p0_quiet", d0_cnt - c0, 32'd0);

    // Stale mdone holds off the grant.
    stale = 1'b1; step();
    p0_type = 2'd1; p0_addr = 24'h000042; p0_wdata = 8'h99; p0_req = 1'b1;
    r0 = rise_cnt; c0 = d0_cnt;
    repeat (4) step();
    chk("t4_no_mreq", rise_cnt - r0, 32'd0);
    chk("t4_no_busy", 32'(busy), 32'd0);
    stale = 1'b0; t0 = cyc; rd_val = 8'h12;
    wait_rise(r0 + 1, 10, "t4_rise");
    chk("t4_grant_latency", last_rise_cyc - t0, 32'd3);
    wait_done(1'b0, c0, 20, "t4_done");
    p0_req = 1'b0;
    step(); step();

    // Reset in the middle of a transaction.
    lat = 10; p0_type = 2'd0; p0_addr = 24'h000055; p0_req = 1'b1;
    r0 = rise_cnt; c0 = d0_cnt; c1 = d1_cnt;
    wait_rise(r0 + 1, 10, "t5_rise");
    step();
    rst_n = 1'b0; p0_req = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_mreq", 32'(mbus.mreq), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    repeat (3) step();
    chk("t5_no_done", d0_cnt - c0, 32'd0);
    lat = 2; rd_val = 8'h33;
    p1_type = 2'd2; p1_addr = 24'h000077; p1_req = 1'b1;
    wait_done(1'b1, c1, 20, "t5_p1_done");
    p1_req = 1'b0;
    step(); step();
    chk("t5_p1_rdata", 32'(rdata), 32'h33);

    // Requester drops req while its transaction is in flight.
    lat = 5; rd_val = 8'hE7;
    p0_type = 2'd0; p0_addr = 24'h000321; p0_req = 1'b1;
    r0 = rise_cnt; c0 = d0_cnt;
    wait_rise(r0 + 1, 10, "t6_rise");
    step();
    p0_req = 1'b0;
    wait_done(1'b0, c0, 20, "t6_done");
    step(); step(); step();
    chk("t6_done_once", d0_cnt - c0, 32'd1);
    chk("t6_rdata", 32'(rdata), 32'hE7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
